// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver FSM states, parity helper.
package uart_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    // Parity bit a transmitter appends to data: even (odd=0) or odd (odd=1).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// A restart pulse realigns the phase; no tick is issued in the restart cycle.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count and tick decode.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == Last) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_receiver.sv
// UART receiver: start + 8 data (LSB first) + parity + stop, oversampled,
// delivering the byte through a valid/ack handshake with sticky overrun.
module uart_frame_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_HZ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DivRaw = CLOCK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int unsigned SampW  = $clog2(OVERSAMPLE);
    localparam int unsigned ShW    = DATA_BITS + 1;

    localparam logic [SampW-1:0] MidCnt  = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] LastCnt = SampW'(OVERSAMPLE - 1);
    localparam logic [3:0]       LastBit = 4'(DATA_BITS);
    localparam logic             Odd     = (PARITY_ODD != 0);

    logic rx_meta_q, rx_s_q;
    logic tick, restart, frame_done;

    rx_state_e        state_q, state_d;
    logic [SampW-1:0] samp_q, samp_d;
    logic [3:0]       bit_q, bit_d;
    logic [ShW-1:0]   shift_q, shift_d;
    logic             armed_q, armed_d;

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       overrun_q, overrun_d;

    uart_baud_tick #(
        .DIV(Div)
    ) u_baud_tick (
        .clock  (clock),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    // Two-flop synchronizer, preset to the idle line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM: next state, sample/bit counters and shift register.
    always_comb begin
        state_d    = state_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        restart    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (armed_q && !rx_s_q) begin
                    state_d = StStart;
                    samp_d  = '0;
                    restart = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    if (samp_q == MidCnt) begin
                        samp_d  = '0;
                        bit_d   = '0;
                        // High at mid start bit is a glitch, not a frame.
                        state_d = rx_s_q ? StIdle : StData;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (samp_q == LastCnt) begin
                        samp_d  = '0;
                        shift_d = {rx_s_q, shift_q[ShW-1:1]};
                        if (bit_q == LastBit) begin
                            state_d = StStop;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (samp_q == LastCnt) begin
                        frame_done = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output registers, handshake and re-arm tracking.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        overrun_d = overrun_q;
        // Re-arm only after the line has been seen high following a stop bit.
        armed_d   = armed_q | rx_s_q;
        if (frame_done) begin
            armed_d = 1'b0;
            data_d  = shift_q[DATA_BITS-1:0];
            perr_d  = shift_q[ShW-1] != parity_bit(shift_q[DATA_BITS-1:0], Odd);
            ferr_d  = ~rx_s_q;
            valid_d = 1'b1;
            if (valid_q && !data_ack) begin
                overrun_d = 1'b1;
            end
        end else if (data_ack) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            samp_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver at DIV=1, 16 clocks per bit.
module tb_uart_frame_receiver;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    logic valid_prev = 1'b0;

    uart_frame_receiver #(
        .CLOCK_HZ  (1600000),
        .BAUD      (100000),
        .OVERSAMPLE(16),
        .PARITY_ODD(0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .data_ack     (data_ack),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record the cycle of each data_valid rising edge.
    always @(negedge clock) begin
        if (data_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = data_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clocks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives a full 11-bit frame; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            wait_clocks(16);
        end
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        wait_clocks(1);
        data_ack = 1'b0;
    endtask

    initial begin
        logic saw_busy;
        logic released;
        int   lat;

        // Reset state
        wait_clocks(3);
        check("rst_data", data_out, 8'h00);
        check("rst_valid", data_valid, 0);
        check("rst_perr", parity_error, 0);
        check("rst_ferr", framing_error, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        wait_clocks(20);

        // 0xA5, correct even parity
        send_frame(8'hA5, 1'b0, 1'b1);
        rx = 1'b1;
        lat = rise_cyc - start_cyc;
        check("a5_latency_window", (lat >= 169 && lat <= 171), 1);
        check("a5_data", data_out, 8'hA5);
        check("a5_valid", data_valid, 1);
        check("a5_perr", parity_error, 0);
        check("a5_ferr", framing_error, 0);
        check("a5_busy", busy, 0);
        ack_pulse();
        check("a5_ack_valid", data_valid, 0);
        wait_clocks(16);

        // 0x3C with wrong parity
        send_frame(8'h3C, 1'b1, 1'b1);
        rx = 1'b1;
        check("3c_data", data_out, 8'h3C);
        check("3c_perr", parity_error, 1);
        check("3c_ferr", framing_error, 0);
        ack_pulse();
        check("3c_ack_valid", data_valid, 0);
        check("3c_perr_held", parity_error, 1);
        wait_clocks(16);

        // 0x00 with stop bit 0, line held low (break) afterwards
        send_frame(8'h00, 1'b0, 1'b0);
        wait_clocks(32);
        check("brk_data", data_out, 8'h00);
        check("brk_ferr", framing_error, 1);
        check("brk_perr", parity_error, 0);
        check("brk_no_retrigger", busy, 0);
        check("brk_valid", data_valid, 1);
        ack_pulse();
        rx = 1'b1;
        wait_clocks(40);
        send_frame(8'h55, 1'b0, 1'b1);
        rx = 1'b1;
        check("55_data", data_out, 8'h55);
        check("55_valid", data_valid, 1);
        check("55_ferr", framing_error, 0);
        check("55_perr", parity_error, 0);
        ack_pulse();
        wait_clocks(16);

        // 4-clock glitch while idle
        rx = 1'b0;
        wait_clocks(4);
        rx = 1'b1;
        saw_busy = busy;
        released = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (!released) begin
                wait_clocks(1);
                if (!busy) released = 1'b1;
            end
        end
        check("glitch_busy_seen", saw_busy, 1);
        check("glitch_busy_clear", released, 1);
        wait_clocks(200);
        check("glitch_no_valid", data_valid, 0);

        // Two frames without ack -> overrun
        send_frame(8'h11, 1'b0, 1'b1);
        rx = 1'b1;
        wait_clocks(8);
        check("ovr_first_clean", overrun, 0);
        send_frame(8'h22, 1'b0, 1'b1);
        rx = 1'b1;
        check("ovr_data", data_out, 8'h22);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", data_valid, 1);
        ack_pulse();
        check("ovr_ack_valid", data_valid, 0);
        check("ovr_sticky", overrun, 1);
        ack_pulse();
        check("ovr_idle_ack_ignored", data_valid, 0);
        wait_clocks(16);

        // Reset during the 5th data bit of 0xFF
        rx = 1'b0;
        wait_clocks(16);
        rx = 1'b1;
        wait_clocks(64 + 8);
        reset = 1'b0;
        #1;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_valid", data_valid, 0);
        check("mid_rst_perr", parity_error, 0);
        check("mid_rst_ferr", framing_error, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_busy", busy, 0);
        wait_clocks(5);
        reset = 1'b1;
        wait_clocks(120);
        check("mid_rst_no_partial", data_valid, 0);
        send_frame(8'h81, 1'b0, 1'b1);
        rx = 1'b1;
        check("81_data", data_out, 8'h81);
        check("81_valid", data_valid, 1);
        check("81_perr", parity_error, 0);
        check("81_overrun", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
